l2_refill_arbiter: RTL and testbench
====================================

L2_REFILL_ARBITER -- requirements
Module: l2_refill_arbiter

Interface
REQ-001 SHALL have parameter B, default 64, giving the cache block size in bytes (power of two, at least 16).
REQ-002 SHALL have parameter A, default 32, giving the address width in bits.
REQ-003 SHALL derive localparam BEATS = B/8, the number of 64-bit beats per block.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 ic_miss_i  input  1  instruction cache requests a block refill.
REQ-007 ic_addr_i  input  A  instruction cache miss address.
REQ-008 dc_miss_i  input  1  data cache requests a block refill.
REQ-009 dc_addr_i  input  A  data cache miss address.
REQ-010 l2_req_o  output  1  refill request to L2.
REQ-011 l2_addr_o  output  A  block-aligned refill address.
REQ-012 l2_ack_i  input  1  L2 accepts the request.
REQ-013 l2_valid_i  input  1  L2 beat valid this cycle.
REQ-014 l2_data_i  input  64  L2 beat data.
REQ-015 ic_repl_grant_o  output  1  instruction cache writes rep_word_o this cycle.
REQ-016 dc_repl_grant_o  output  1  data cache writes rep_word_o this cycle.
REQ-017 rep_word_o  output  64  refill beat, driven as l2_data_i passed through combinationally.
REQ-018 busy_o  output  1  asserted whenever the state is not IDLE.

Function
REQ-019 SHALL implement three states: IDLE, REQ, XFER.
REQ-020 In IDLE with any miss asserted, the arbiter SHALL select an owner, latch the owner's address with its low log2(B) bits cleared into l2_addr_o, and enter REQ on the next edge.
REQ-021 Owner selection SHALL follow these rules:
  - only one miss asserted: that requester wins;
  - both asserted: the requester that was not last_owner wins (round-robin).
REQ-022 last_owner SHALL update when the arbiter leaves XFER.
REQ-023 In REQ, l2_req_o SHALL be 1 and l2_addr_o SHALL be held stable.
REQ-024 In REQ, on l2_ack_i=1 the arbiter SHALL enter XFER with the beat counter at 0.
REQ-025 In REQ, if the owner's miss deasserts before ack, the arbiter SHALL return to IDLE without updating last_owner, and l2_req_o SHALL drop the same cycle.
REQ-026 In XFER, l2_req_o SHALL be 0.
REQ-027 In XFER, each cycle with l2_valid_i=1 SHALL increment the beat counter (width log2(BEATS)).
REQ-028 In XFER, the owner's grant SHALL equal l2_valid_i AND owner miss, so the grant is one cycle per beat with zero latency.
REQ-029 The non-owner's grant SHALL remain 0 throughout.
REQ-030 A beat arriving with the counter at BEATS-1 SHALL return the arbiter to IDLE and wrap the counter to 0.
REQ-031 If the owner's miss drops during XFER, the remaining beats SHALL be drained to completion with the grant suppressed.
REQ-032 l2_valid_i SHALL be ignored outside XFER.
REQ-033 An l2_ack_i arriving in the same cycle the owner's miss drops SHALL be treated as the abort case (REQ-025).
REQ-034 A new arbitration SHALL NOT start in the cycle XFER exits; IDLE lasts at least one cycle.
REQ-035 A miss held across IDLE SHALL be granted within two refills.

Reset
REQ-036 While reset_ni=0, the following SHALL hold immediately:
  - state = IDLE;
  - l2_req_o = 0, both grants = 0, busy_o = 0;
  - l2_addr_o = 0, beat counter = 0;
  - last_owner = DC, so IC wins the first tie.
REQ-037 Reset asserted mid-REQ or mid-XFER SHALL abandon the transfer; after release the arbiter SHALL re-arbitrate from IDLE.

Structure
REQ-038 cache_pkg SHALL hold the following shared definitions:
  - the refill_state_t enum {IDLE, REQ, XFER};
  - the owner_t enum {OWN_IC, OWN_DC};
  - the BEAT_W helper constant.
REQ-039 A single sub-module rr_arb2 (2-way round-robin picker: two request bits plus last_owner in, one-hot winner out, combinational) SHALL be instantiated.
REQ-040 The beat counter and FSM SHALL stay inline.

Verification
REQ-041 IC miss only, addr 0x0000_1234, ack after 2 cycles, 8 valid beats back-to-back -> l2_addr_o=0x0000_1200, ic_repl_grant_o high exactly 8 cycles, then IDLE.
REQ-042 IC and DC miss together from reset -> IC served first; DC then wins REQ after one IDLE cycle; next tie after that goes to IC.
REQ-043 Beats with l2_valid_i gaps (pattern 1,0,0,1...) -> grant mirrors valid; exit only after the 8th valid beat.
REQ-044 Owner miss dropped in REQ before ack -> l2_req_o falls the same cycle; IDLE next; last_owner unchanged.
REQ-045 Owner miss dropped after beat 3 -> beats 4-8 consumed with grant 0; busy_o falls after beat 8.
REQ-046 reset_ni pulsed low during beat 5 -> all outputs 0 asynchronously; fresh REQ after release if miss still high.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 refill path: FSM states, owner encoding, beat-counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: refill_state_t, owner_t, BEAT_W (default 64-byte block), beat_w_f() for other block sizes.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } refill_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Beat counter width for the default 64-byte block (8 beats of 64 bits).
    localparam int BEAT_W = 3;

    // Beat counter width for an arbitrary beat count; never narrower than one bit.
    function automatic int beat_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whoever was not last owner.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req_i[0]=IC, req_i[1]=DC request; last_i = previous owner; gnt_o one-hot winner (or 0).
module rr_arb2
    import cache_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == OWN_DC) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/l2_refill_arbiter.sv
// Arbitrates I-cache and D-cache block refills onto one L2 port and steers returned beats.
// Latency: REQ one cycle after a miss is seen in IDLE; beat grants are zero-latency from l2_valid_i.
// Backpressure: l2_req_o held until l2_ack_i; beats are never stalled, a dropped owner miss drains them.
// Ports: clk_i/reset_ni; ic/dc miss+addr in; l2_req_o/l2_addr_o/l2_ack_i request side;
//        l2_valid_i/l2_data_i beat side; ic/dc_repl_grant_o, rep_word_o, busy_o toward the caches.
module l2_refill_arbiter
    import cache_pkg::*;
#(
    parameter int B = 64,
    parameter int A = 32
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          ic_miss_i,
    input  logic [A-1:0]  ic_addr_i,
    input  logic          dc_miss_i,
    input  logic [A-1:0]  dc_addr_i,
    output logic          l2_req_o,
    output logic [A-1:0]  l2_addr_o,
    input  logic          l2_ack_i,
    input  logic          l2_valid_i,
    input  logic [63:0]   l2_data_i,
    output logic          ic_repl_grant_o,
    output logic          dc_repl_grant_o,
    output logic [63:0]   rep_word_o,
    output logic          busy_o
);

    localparam int BEATS = B / 8;
    localparam int CNT_W = beat_w_f(BEATS);
    localparam int OFF_W = $clog2(B);
    localparam logic [A-1:0]     ADDR_MASK = {A{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_t    state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_owner_q, last_owner_d;
    logic [A-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic [1:0] win;
    logic       owner_miss;

    rr_arb2 u_rr_arb2 (
        .req_i  ({dc_miss_i, ic_miss_i}),
        .last_i (last_owner_q),
        .gnt_o  (win)
    );

    assign owner_miss = (owner_q == OWN_IC) ? ic_miss_i : dc_miss_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_DC;   // IC wins the first tie
            addr_q       <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (ic_miss_i || dc_miss_i) begin
                    owner_d = win[1] ? OWN_DC : OWN_IC;
                    addr_d  = (win[1] ? dc_addr_i : ic_addr_i) & ADDR_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A miss withdrawn in the ack cycle still aborts; last owner is left alone.
                if (!owner_miss) begin
                    state_d = IDLE;
                end else if (l2_ack_i) begin
                    state_d = XFER;
                    beat_d  = '0;
                end
            end
            XFER: begin
                // Beats are always consumed, even with the owner gone, so L2 is never left mid-block.
                if (l2_valid_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d       = '0;
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign l2_req_o        = (state_q == REQ) && owner_miss;
    assign l2_addr_o       = addr_q;
    assign ic_repl_grant_o = (state_q == XFER) && (owner_q == OWN_IC) && l2_valid_i && ic_miss_i;
    assign dc_repl_grant_o = (state_q == XFER) && (owner_q == OWN_DC) && l2_valid_i && dc_miss_i;
    assign rep_word_o      = l2_data_i;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Directed bench for l2_refill_arbiter with 64-byte blocks and 32-bit addresses.
// Latency: inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// Backpressure: L2 ack/valid are driven directly by the directed steps.
module tb_l2_refill_arbiter;

    logic        clk;
    logic        reset_ni;
    logic        ic_miss, dc_miss;
    logic [31:0] ic_addr, dc_addr;
    logic        l2_req;
    logic [31:0] l2_addr;
    logic        l2_ack, l2_valid;
    logic [63:0] l2_data;
    logic        ic_gnt, dc_gnt;
    logic [63:0] rep_word;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int gcnt;
    int vcnt;

    l2_refill_arbiter #(.B(64), .A(32)) dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .ic_miss_i       (ic_miss),
        .ic_addr_i       (ic_addr),
        .dc_miss_i       (dc_miss),
        .dc_addr_i       (dc_addr),
        .l2_req_o        (l2_req),
        .l2_addr_o       (l2_addr),
        .l2_ack_i        (l2_ack),
        .l2_valid_i      (l2_valid),
        .l2_data_i       (l2_data),
        .ic_repl_grant_o (ic_gnt),
        .dc_repl_grant_o (dc_gnt),
        .rep_word_o      (rep_word),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_ni = 1'b0;
        ic_miss  = 1'b1;
        dc_miss  = 1'b1;
        ic_addr  = 32'h0000_1234;
        dc_addr  = 32'h0000_5678;
        l2_ack   = 1'b0;
        l2_valid = 1'b0;
        l2_data  = 64'd0;

        // Reset state, with misses pending
        #3;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_req", l2_req, 1'b0);
        chk_b("rst_icg", ic_gnt, 1'b0);
        chk_b("rst_dcg", dc_gnt, 1'b0);
        chk_w("rst_addr", 64'(l2_addr), 64'h0);
        repeat (2) @(posedge clk);
        #2;
        ic_miss  = 1'b0;
        dc_miss  = 1'b0;
        reset_ni = 1'b1;

        // IC-only refill, ack on second REQ cycle, 8 back-to-back beats
        ic_miss = 1'b1;
        #1 chk_b("t1_idle_busy", busy, 1'b0);
        tick;
        #1;
        chk_b("t1_req", l2_req, 1'b1);
        chk_w("t1_addr", 64'(l2_addr), 64'h0000_1200);
        chk_b("t1_busy", busy, 1'b1);
        tick;
        l2_ack = 1'b1;
        #1 chk_b("t1_req_hold", l2_req, 1'b1);
        tick;
        l2_ack   = 1'b0;
        l2_valid = 1'b1;
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            l2_data = 64'hA5A5_0000_0000_0000 | 64'(i);
            #1;
            chk_b("t1_xfer_req", l2_req, 1'b0);
            chk_b("t1_dcg", dc_gnt, 1'b0);
            chk_w("t1_word", rep_word, 64'hA5A5_0000_0000_0000 | 64'(i));
            if (ic_gnt) gcnt++;
            tick;
        end
        l2_valid = 1'b0;
        ic_miss  = 1'b0;
        #1;
        chk_b("t1_done_busy", busy, 1'b0);
        chk_w("t1_gnt_cycles", 64'(gcnt), 64'd8);
        tick;

        // Tie from reset: IC first, DC next, then IC again
        reset_ni = 1'b0;
        #1 reset_ni = 1'b1;
        ic_miss = 1'b1;
        dc_miss = 1'b1;
        ic_addr = 32'h1000_007F;
        dc_addr = 32'h2000_0085;
        tick;
        #1;
        chk_w("t2_addr_ic", 64'(l2_addr), 64'h1000_0040);
        chk_b("t2_req_ic", l2_req, 1'b1);
        l2_ack = 1'b1;
        tick;
        l2_ack   = 1'b0;
        l2_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_b("t2_icg", ic_gnt, 1'b1);
            chk_b("t2_dcg_off", dc_gnt, 1'b0);
            tick;
        end
        l2_valid = 1'b0;
        #1 chk_b("t2_idle_gap", busy, 1'b0);
        tick;
        #1 chk_w("t2_addr_dc", 64'(l2_addr), 64'h2000_0080);
        l2_ack = 1'b1;
        tick;
        l2_ack   = 1'b0;
        l2_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_b("t2_dcg", dc_gnt, 1'b1);
            chk_b("t2_icg_off", ic_gnt, 1'b0);
            tick;
        end
        l2_valid = 1'b0;
        #1 chk_b("t2_idle_gap2", busy, 1'b0);
        tick;
        #1 chk_w("t2_tie_ic", 64'(l2_addr), 64'h1000_0040);

        // Owner miss withdrawn before ack: request drops at once, last owner kept
        ic_miss = 1'b0;
        #1;
        chk_b("t3_abort_req", l2_req, 1'b0);
        chk_b("t3_abort_busy", busy, 1'b1);
        tick;
        ic_miss = 1'b1;
        #1 chk_b("t3_idle", busy, 1'b0);
        tick;
        #1 chk_w("t3_tie_still_ic", 64'(l2_addr), 64'h1000_0040);
        // Ack in the same cycle the miss drops is still an abort
        l2_ack  = 1'b1;
        ic_miss = 1'b0;
        #1 chk_b("t3_ack_abort_req", l2_req, 1'b0);
        tick;
        l2_ack  = 1'b0;
        dc_miss = 1'b0;
        #1 chk_b("t3_ack_abort_idle", busy, 1'b0);
        tick;

        // DC refill with valid gaps 1,0,0,1,...
        dc_miss = 1'b1;
        tick;
        l2_ack = 1'b1;
        tick;
        l2_ack = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 22; c++) begin
            l2_valid = ((c % 3) == 0);
            #1;
            chk_b("t4_gnt_mirror", dc_gnt, l2_valid);
            chk_b("t4_busy", busy, 1'b1);
            if (l2_valid) vcnt++;
            tick;
        end
        l2_valid = 1'b0;
        dc_miss  = 1'b0;
        #1;
        chk_b("t4_done", busy, 1'b0);
        chk_w("t4_valids", 64'(vcnt), 64'd8);
        tick;

        // IC miss dropped after beat 3: remaining beats drained without grant
        ic_miss = 1'b1;
        ic_addr = 32'h0000_3FC1;
        tick;
        #1 chk_w("t5_addr", 64'(l2_addr), 64'h0000_3FC0);
        l2_ack = 1'b1;
        tick;
        l2_ack   = 1'b0;
        l2_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) ic_miss = 1'b0;
            #1;
            chk_b("t5_gnt", ic_gnt, (i < 3));
            chk_b("t5_busy", busy, 1'b1);
            tick;
        end
        l2_valid = 1'b0;
        #1 chk_b("t5_done", busy, 1'b0);
        tick;

        // Reset pulsed during beat 5: everything clears asynchronously, fresh REQ after
        ic_miss = 1'b1;
        tick;
        l2_ack = 1'b1;
        tick;
        l2_ack   = 1'b0;
        l2_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        #1 chk_b("t6_beat5_gnt", ic_gnt, 1'b1);
        reset_ni = 1'b0;
        #1;
        chk_b("t6_rst_gnt", ic_gnt, 1'b0);
        chk_b("t6_rst_busy", busy, 1'b0);
        chk_b("t6_rst_req", l2_req, 1'b0);
        chk_w("t6_rst_addr", 64'(l2_addr), 64'h0);
        #2;
        reset_ni = 1'b1;
        l2_valid = 1'b0;
        tick;
        #1;
        chk_b("t6_fresh_req", l2_req, 1'b1);
        chk_w("t6_fresh_addr", 64'(l2_addr), 64'h0000_3FC0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
